// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver.
// Scans DIGITS hex nibbles from the leftmost digit (DIGITS-1) down to digit 0.
// Each digit slot is DIV clocks long. The first clock of every slot is a dark guard
// cycle that prevents ghosting between digits.
// Inputs are captured into shadow registers at frame start, so the picture never
// tears mid-frame.
// Handshake: none. Inputs are level-sampled. frame_tick is a single-cycle strobe
// with no back-pressure.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 150000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  zero_blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [FC_W-1:0]     r_frame_cnt;
  logic                r_blink_phase;
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blink;
  logic                r_sh_zb;

  logic [3:0]          w_nibble;
  logic                w_dp;
  logic                w_blink;
  logic                w_lz;
  logic                w_run;
  logic [DIGITS-1:0]   w_an_sel;
  logic                w_blank;
  logic                w_slot_end;
  logic                w_frame_end;
  logic                w_snap;

  // Segment pattern g..a, active low, for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h18;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == '0);
  assign w_snap      = enable && (r_idx == IDX_FIRST) && (r_cnt == '0);

  // Select the current digit's shadow fields and evaluate leading-zero suppression.
  // w_run is true while every digit from the leftmost down to digit k is zero.
  always_comb begin
    w_nibble = 4'h0;
    w_dp     = 1'b0;
    w_blink  = 1'b0;
    w_lz     = 1'b0;
    w_run    = 1'b1;
    w_an_sel = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run = w_run & (r_sh_data[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_nibble = r_sh_data[4*k +: 4];
        w_dp     = r_sh_dp[k];
        w_blink  = r_sh_blink[k];
        w_lz     = w_run;
      end
      w_an_sel[k] = (r_idx != IDX_W'(k));
    end
  end

  // Digit 0 is never zero-blanked so a zero value still shows one "0"
  assign w_blank = (r_sh_zb && w_lz && (r_idx != '0)) || (r_blink_phase && w_blink);

  // Prescaler and digit index; held at frame start while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= IDX_FIRST;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= IDX_FIRST;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == '0) ? IDX_FIRST : r_idx - IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame-start snapshot of everything the display shows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blink <= '0;
      r_sh_zb    <= 1'b0;
    end else if (w_snap) begin
      r_sh_data  <= data;
      r_sh_dp    <= dp_mask;
      r_sh_blink <= blink_mask;
      r_sh_zb    <= zero_blank;
    end
  end

  // Blink phase toggles every BLINK_FRAMES completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (enable && w_frame_end) begin
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + FC_W'(1);
      end
    end
  end

  // Registered pin drive: dark on reset, disable, guard cycle or blanked digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 8'hFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      seg        <= 8'hFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_frame_end;
      if ((r_cnt == '0) || w_blank) begin
        seg <= 8'hFF;
        an  <= '1;
      end else begin
        seg <= {~w_dp, hex7(w_nibble)};
        an  <= w_an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=8, DIV=4, BLINK_FRAMES=2.
// A frame-position reference model predicts every pin each cycle; directed
// checks cover the documented scenarios, then randomized stimulus follows.
module tb_seg7_scan_driver;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int BF     = 2;
  localparam int FRAME  = DIGITS * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              enable = 1'b0;
  logic [31:0]       data = '0;
  logic [7:0]        dp_mask = '0;
  logic [7:0]        blink_mask = '0;
  logic              zero_blank = 1'b0;
  logic [7:0]        seg;
  logic [7:0]        an;
  logic              frame_tick;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .zero_blank(zero_blank), .seg(seg), .an(an),
    .frame_tick(frame_tick)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: position inside the frame, completed frames, frame snapshot
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_pos;
  int          m_frames;
  logic [31:0] s_data;
  logic [7:0]  s_dp, s_blink;
  logic        s_zb;
  logic [7:0]  e_seg, e_an;
  logic        e_tick;

  always @(posedge clk or negedge rst_n) begin
    int dig, sub, nib;
    bit phase, blank;
    if (!rst_n) begin
      m_pos = 0; m_frames = 0;
      s_data = '0; s_dp = '0; s_blink = '0; s_zb = 1'b0;
      e_seg = 8'hFF; e_an = 8'hFF; e_tick = 1'b0;
    end else if (!enable) begin
      m_pos = 0;
      e_seg = 8'hFF; e_an = 8'hFF; e_tick = 1'b0;
    end else begin
      if (m_pos == 0) begin
        s_data = data; s_dp = dp_mask; s_blink = blink_mask; s_zb = zero_blank;
      end
      dig   = DIGITS - 1 - m_pos / DIV;
      sub   = m_pos % DIV;
      nib   = int'((s_data >> (4 * dig)) & 32'hF);
      phase = ((m_frames / BF) % 2) == 1;
      blank = (s_zb && dig != 0 && (s_data >> (4 * dig)) == 0) || (phase && s_blink[dig]);
      if (sub == 0 || blank) begin
        e_seg = 8'hFF; e_an = 8'hFF;
      end else begin
        e_an  = ~(8'd1 << dig);
        e_seg = {~s_dp[dig], hex_tab[nib][6:0]};
      end
      e_tick = (m_pos == FRAME - 1);
      m_pos++;
      if (m_pos == FRAME) begin
        m_pos = 0;
        m_frames++;
      end
    end
  end

  // driver: advance one cycle and compare all pins against the model
  task automatic cyc(input string tag);
    @(negedge clk);
    check({tag, ".seg"},  32'(seg),        32'(e_seg));
    check({tag, ".an"},   32'(an),         32'(e_an));
    check({tag, ".tick"}, 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  logic [7:0] t1_an  [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] t1_seg [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'h8E};

  initial begin
    // reset state
    @(negedge clk);
    check("rst.seg", 32'(seg), 32'hFF);
    check("rst.an", 32'(an), 32'hFF);
    check("rst.tick", 32'(frame_tick), 32'h0);

    // test 1: plain scan with fixed expected table
    data = 32'h1234ABCF; enable = 1'b1; rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < DIV; c++) begin
        cyc("t1m");
        check("t1.an", 32'(an), (c == 0) ? 32'hFF : 32'(t1_an[s]));
        check("t1.seg", 32'(seg), (c == 0) ? 32'hFF : 32'(t1_seg[s]));
        check("t1.tick", 32'(frame_tick), (s == 7 && c == DIV - 1) ? 32'h1 : 32'h0);
      end
    end

    // test 2: data change while digit 5 is shown takes effect next frame
    run("t2a", 2 * DIV + 2);
    data = 32'h0;
    run("t2b", FRAME - 2 * DIV - 2 + FRAME);

    // test 3: leading-zero suppression
    zero_blank = 1'b1; data = 32'h00000450;
    run("t3a", 2 * FRAME);
    data = 32'h0;
    run("t3b", 2 * FRAME);

    // test 4: blink on digit 0
    zero_blank = 1'b0; blink_mask = 8'h01; data = 32'h8;
    run("t4", 5 * FRAME);

    // test 5: decimal point on digit 2
    blink_mask = 8'h00; dp_mask = 8'h04; data = 32'h800;
    run("t5", 2 * FRAME);

    // test 6: async reset mid-slot, then disable/re-enable
    dp_mask = 8'h00; data = 32'h1234ABCF;
    run("t6a", 6);
    #2 rst_n = 1'b0;
    #1;
    check("t6.async_seg", 32'(seg), 32'hFF);
    check("t6.async_an", 32'(an), 32'hFF);
    run("t6b", 3);
    rst_n = 1'b1;
    cyc("t6c");
    cyc("t6d");
    check("t6.first_lit", 32'(an), 32'h7F);
    run("t6e", 9);
    enable = 1'b0;
    run("t6f", 10);
    check("t6.dis_an", 32'(an), 32'hFF);
    enable = 1'b1;
    cyc("t6g");
    cyc("t6h");
    check("t6.restart", 32'(an), 32'h7F);

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        data       = $urandom() >> $urandom_range(0, 31);
        dp_mask    = 8'($urandom());
        blink_mask = 8'($urandom());
        zero_blank = 1'($urandom());
      end
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
